// File: rtl/lc3_fetch_prefetch_pkg.sv
// Shared constants and helpers for the LC-3 fetch/prefetch slice:
// opcode values of the control-flow instructions and offset sign extension.
package lc3_fetch_prefetch_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_BR  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_JSR = 4'b0100;
  localparam logic [OPC_W-1:0] OP_JMP = 4'b1100;

  // PCoffset9 of BR, widened to 32 bits so callers can truncate to any PC width
  function automatic logic [31:0] sext9(input logic [8:0] v);
    return {{23{v[8]}}, v};
  endfunction

  // PCoffset11 of JSR, widened the same way
  function automatic logic [31:0] sext11(input logic [10:0] v);
    return {{21{v[10]}}, v};
  endfunction

endpackage

// File: rtl/lc3_fetch_prefetch_if.sv
// Bundle of every non-clock signal of the fetch unit: execute-side redirect
// inputs, instruction memory read port and the decode-side head of queue.
// The master modport is the fetch unit; slave is its environment.
interface lc3_fetch_prefetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              fetch_en;
  logic              resolve_valid;
  logic [ADDR_W-1:0] resolve_pc;
  logic [3:0]        opCode_in;
  logic [11:0]       offset_in;
  logic [ADDR_W-1:0] reg_in;
  logic [2:0]        br_nzp;
  logic [2:0]        result_nzp;
  logic [ADDR_W-1:0] addr_out;
  logic              rd_req;
  logic              wea_out;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] pc;
  logic              redirect_out;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    input  fetch_en, resolve_valid, resolve_pc, opCode_in, offset_in, reg_in,
           br_nzp, result_nzp, mem_rvalid, mem_rdata, instr_ready,
    output addr_out, rd_req, wea_out, instr_valid, instr_out, instr_pc, pc,
           redirect_out, fifo_count
  );

  modport slave (
    output fetch_en, resolve_valid, resolve_pc, opCode_in, offset_in, reg_in,
           br_nzp, result_nzp, mem_rvalid, mem_rdata, instr_ready,
    input  addr_out, rd_req, wea_out, instr_valid, instr_out, instr_pc, pc,
           redirect_out, fifo_count
  );

endinterface

// File: rtl/lc3_fetch_prefetch_fifo.sv
// Show-ahead synchronous FIFO holding {pc, instruction} pairs.
// A flush empties it in one edge and wins over a push or pop in that cycle.
module lc3_fetch_prefetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign doPop   = pop_i && (count_q != '0);
  assign doPush  = push_i && ((count_q < CNT_W'(DEPTH)) || doPop);
  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  assign rdata_o = store_q[rdPtr_q];

  // Next pointers and occupancy; a flush resets all three
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      if (doPush && !doPop)      count_d = count_q + CNT_W'(1);
      else if (doPop && !doPush) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are meaningless while count is zero, so no reset
  always_ff @(posedge clk) begin
    if (doPush && !flush_i) store_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/lc3_fetch_prefetch.sv
// LC-3 fetch unit: issues one outstanding instruction read at a time, buffers
// returned words in a prefetch queue and redirects on taken BR/JMP/JSR,
// discarding the stale word of a read that was in flight at the redirect.
module lc3_fetch_prefetch
  import lc3_fetch_prefetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                  clk,
  input logic                  rst,
  lc3_fetch_prefetch_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] reqPc_q, reqPc_d;
  logic              rdReq_q, rdReq_d;
  logic              pending_q, pending_d;
  logic              drop_q, drop_d;
  logic              redirect_q, redirect_d;

  logic              taken;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pcPlus1;
  logic [ADDR_W-1:0] brOff;
  logic [ADDR_W-1:0] jsrOff;
  logic              issue;
  logic              resp;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  fifoCount;
  logic [CNT_W:0]    occupancy;
  logic              headValid;
  logic [ADDR_W+DATA_W-1:0] headData;

  assign pcPlus1 = bus.resolve_pc + ADDR_W'(1);
  assign brOff   = ADDR_W'(sext9(bus.offset_in[8:0]));
  assign jsrOff  = ADDR_W'(sext11(bus.offset_in[10:0]));

  // Decide whether the resolved instruction changes control flow, and where to
  always_comb begin
    taken  = 1'b0;
    target = bus.reg_in;
    if (bus.resolve_valid) begin
      case (bus.opCode_in)
        OP_BR: begin
          taken  = |(bus.br_nzp & bus.result_nzp);
          target = pcPlus1 + brOff;
        end
        OP_JMP: begin
          taken  = 1'b1;
          target = bus.reg_in;
        end
        OP_JSR: begin
          taken  = 1'b1;
          target = bus.offset_in[11] ? (pcPlus1 + jsrOff) : bus.reg_in;
        end
        default: begin
          taken  = 1'b0;
          target = bus.reg_in;
        end
      endcase
    end
  end

  // Counting the in-flight read against capacity guarantees its word has a slot
  assign occupancy = {1'b0, fifoCount} + {{CNT_W{1'b0}}, pending_q};
  assign issue     = bus.fetch_en && !pending_q && !taken
                     && (occupancy < (CNT_W+1)'(DEPTH));
  assign resp      = bus.mem_rvalid && pending_q;
  assign push      = resp && !drop_q && !taken;
  assign pop       = headValid && bus.instr_ready;

  // Next-state of PC, request and in-flight bookkeeping; a redirect overrides
  always_comb begin
    pc_d       = pc_q;
    addr_d     = addr_q;
    reqPc_d    = reqPc_q;
    rdReq_d    = issue;
    pending_d  = pending_q;
    drop_d     = drop_q;
    redirect_d = taken;
    if (resp) begin
      pending_d = 1'b0;
      drop_d    = 1'b0;
    end
    if (issue) begin
      pending_d = 1'b1;
      reqPc_d   = pc_q;
      addr_d    = pc_q;
      pc_d      = pc_q + ADDR_W'(1);
    end
    if (taken) begin
      pc_d   = target;
      drop_d = pending_q && !resp;
    end
  end

  // Fetch state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      addr_q     <= '0;
      reqPc_q    <= '0;
      rdReq_q    <= 1'b0;
      pending_q  <= 1'b0;
      drop_q     <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      reqPc_q    <= reqPc_d;
      rdReq_q    <= rdReq_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      redirect_q <= redirect_d;
    end
  end

  lc3_fetch_prefetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (taken),
    .push_i  (push),
    .wdata_i ({reqPc_q, bus.mem_rdata}),
    .pop_i   (pop),
    .rdata_o (headData),
    .valid_o (headValid),
    .count_o (fifoCount)
  );

  assign bus.addr_out     = addr_q;
  assign bus.rd_req       = rdReq_q;
  assign bus.wea_out      = 1'b0;
  assign bus.instr_valid  = headValid;
  assign bus.instr_out    = headData[DATA_W-1:0];
  assign bus.instr_pc     = headData[DATA_W +: ADDR_W];
  assign bus.pc           = pc_q;
  assign bus.redirect_out = redirect_q;
  assign bus.fifo_count   = fifoCount;

endmodule

// File: tb/tb_lc3_fetch_prefetch.sv
// Self-checking bench for lc3_fetch_prefetch: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_lc3_fetch_prefetch;
  import lc3_fetch_prefetch_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rstHi = 1'b1;

  always #5 clk = ~clk;

  lc3_fetch_prefetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  lc3_fetch_prefetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) busHi ();

  lc3_fetch_prefetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  lc3_fetch_prefetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(16'hFFFE)
  ) dutHi (
    .clk (clk),
    .rst (rstHi),
    .bus (busHi)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state: expected queue contents and registered outputs
  logic [15:0] mPc, mAddr, mReqPc;
  bit          mPending, mDrop, mRdReq, mRedirect;
  logic [31:0] mQ[$];

  // Memory responder and observation logs
  int          cycleIdx = 0;
  int          respAt   = -1;
  int          memLat   = 1;
  bit          spurOn   = 1'b0;
  logic [15:0] respAddr;
  logic [15:0] popLog[$];
  logic [15:0] rdReqLog[$];
  int          redirectCount;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycleIdx);
    end
  endtask

  function automatic logic [15:0] memData(input logic [15:0] a);
    return 16'((a * 16'h9E37) ^ 16'h5A5A);
  endfunction

  task automatic modelReset();
    mPc = 16'h0000; mAddr = 16'h0000; mReqPc = 16'h0000;
    mPending = 0; mDrop = 0; mRdReq = 0; mRedirect = 0;
    mQ.delete();
    respAt = -1;
  endtask

  task automatic checkAll();
    checkOutput("instr_valid", 32'(bus.instr_valid), 32'(mQ.size() != 0));
    checkOutput("fifo_count", 32'(bus.fifo_count), 32'(mQ.size()));
    if (mQ.size() != 0) begin
      checkOutput("instr_pc", 32'(bus.instr_pc), 32'(mQ[0][31:16]));
      checkOutput("instr_out", 32'(bus.instr_out), 32'(mQ[0][15:0]));
    end
    checkOutput("pc", 32'(bus.pc), 32'(mPc));
    checkOutput("rd_req", 32'(bus.rd_req), 32'(mRdReq));
    checkOutput("addr_out", 32'(bus.addr_out), 32'(mAddr));
    checkOutput("redirect_out", 32'(bus.redirect_out), 32'(mRedirect));
    checkOutput("wea_out", 32'(bus.wea_out), 32'd0);
  endtask

  // Called at a falling edge with execute/decode inputs already on the bus
  task automatic stepCycle();
    bit          taken, issue, resp, pop;
    logic [15:0] target;
    int          o;
    checkAll();

    taken  = 0;
    target = bus.reg_in;
    if (bus.resolve_valid) begin
      if (bus.opCode_in == OP_BR) begin
        taken  = (bus.br_nzp & bus.result_nzp) != 3'b000;
        o      = int'($signed(bus.offset_in[8:0]));
        target = 16'(int'(bus.resolve_pc) + 1 + o);
      end else if (bus.opCode_in == OP_JMP) begin
        taken = 1;
      end else if (bus.opCode_in == OP_JSR) begin
        taken = 1;
        if (bus.offset_in[11]) begin
          o      = int'($signed(bus.offset_in[10:0]));
          target = 16'(int'(bus.resolve_pc) + 1 + o);
        end
      end
    end

    if (bus.rd_req) begin
      respAt   = cycleIdx + memLat;
      respAddr = bus.addr_out;
      rdReqLog.push_back(bus.addr_out);
    end
    if (bus.redirect_out) redirectCount++;
    if (bus.instr_valid && bus.instr_ready && !taken) popLog.push_back(bus.instr_pc);

    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'($urandom);
    if (respAt == cycleIdx) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = memData(respAddr);
      respAt         = -1;
    end else if (spurOn && respAt < 0 && !mPending && $urandom_range(0, 5) == 0) begin
      bus.mem_rvalid = 1'b1;
    end

    issue = bus.fetch_en && !mPending && !taken && (mQ.size() + int'(mPending)) < DEPTH;
    resp  = bus.mem_rvalid && mPending;
    pop   = (mQ.size() != 0) && bus.instr_ready;

    mRdReq    = issue;
    mRedirect = taken;
    if (issue) mAddr = mPc;
    if (taken) begin
      mQ.delete();
      mDrop    = mPending && !resp;
      mPending = mPending && !resp;
      mPc      = target;
    end else begin
      if (pop) void'(mQ.pop_front());
      if (resp) begin
        if (!mDrop) mQ.push_back({mReqPc, memData(mReqPc)});
        mDrop    = 0;
        mPending = 0;
      end
      if (issue) begin
        mPending = 1;
        mReqPc   = mPc;
        mPc      = mPc + 16'd1;
      end
    end

    cycleIdx++;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit fe, input bit rdy, input bit rv, input logic [3:0] op,
                               input logic [15:0] rpc, input logic [11:0] off,
                               input logic [15:0] regv, input logic [2:0] bnzp,
                               input logic [2:0] rnzp);
    bus.fetch_en      = fe;
    bus.instr_ready   = rdy;
    bus.resolve_valid = rv;
    bus.opCode_in     = op;
    bus.resolve_pc    = rpc;
    bus.offset_in     = off;
    bus.reg_in        = regv;
    bus.br_nzp        = bnzp;
    bus.result_nzp    = rnzp;
    stepCycle();
  endtask

  task automatic idle(input bit fe, input bit rdy);
    applyStimulus(fe, rdy, 1'b0, 4'($urandom), 16'($urandom), 12'($urandom),
                  16'($urandom), 3'($urandom), 3'($urandom));
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.fetch_en = 0; bus.instr_ready = 0; bus.resolve_valid = 0; bus.mem_rvalid = 0;
    repeat (5) @(negedge clk);
    modelReset();
    checkAll();
    rst = 1'b0;
  endtask

  logic [31:0] firstVal;
  logic [15:0] hiLog[$];
  bit          respNext;

  initial begin
    bus.fetch_en = 0; bus.resolve_valid = 0; bus.resolve_pc = 0; bus.opCode_in = 0;
    bus.offset_in = 0; bus.reg_in = 0; bus.br_nzp = 0; bus.result_nzp = 0;
    bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.instr_ready = 0;
    busHi.fetch_en = 0; busHi.resolve_valid = 0; busHi.resolve_pc = 0; busHi.opCode_in = 0;
    busHi.offset_in = 0; busHi.reg_in = 0; busHi.br_nzp = 0; busHi.result_nzp = 0;
    busHi.mem_rvalid = 0; busHi.mem_rdata = 0; busHi.instr_ready = 0;

    // Streaming with decode always ready and ADD resolves that must not redirect
    $display("[TB] scenario 1: streaming fetch");
    doReset();
    memLat = 1;
    popLog.delete();
    repeat (20) applyStimulus(1, 1, 1, 4'b0001, 16'($urandom), 12'($urandom),
                              16'($urandom), 3'b111, 3'b111);
    for (int i = 0; i < 4; i++) begin
      firstVal = (popLog.size() > i) ? 32'(popLog[i]) : 32'hFFFF_FFFF;
      checkOutput("t1_order", firstVal, 32'(i));
    end

    // Decode stalled: exactly DEPTH reads, then the queue sits full
    $display("[TB] scenario 2: fill queue");
    doReset();
    rdReqLog.delete();
    repeat (20) idle(1, 0);
    checkOutput("t2_reqs", 32'(rdReqLog.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      firstVal = (rdReqLog.size() > i) ? 32'(rdReqLog[i]) : 32'hFFFF_FFFF;
      checkOutput("t2_addr", firstVal, 32'(i));
    end
    checkOutput("t2_count", 32'(bus.fifo_count), 32'(DEPTH));

    // Taken BR back to 0x0004 flushes the full queue
    $display("[TB] scenario 3: taken branch");
    rdReqLog.delete();
    applyStimulus(1, 0, 1, OP_BR, 16'd5, 12'h1FE, 16'h0, 3'b010, 3'b010);
    checkOutput("t3_count", 32'(bus.fifo_count), 32'd0);
    checkOutput("t3_redirect", 32'(bus.redirect_out), 32'd1);
    repeat (5) idle(1, 0);
    firstVal = (rdReqLog.size() > 0) ? 32'(rdReqLog[0]) : 32'hFFFF_FFFF;
    checkOutput("t3_next_addr", firstVal, 32'h0004);

    // Untaken BR leaves the stream alone
    $display("[TB] scenario 4: untaken branch");
    redirectCount = 0;
    repeat (12) applyStimulus(1, 1, 1, OP_BR, 16'd5, 12'h1FE, 16'h0, 3'b100, 3'b001);
    checkOutput("t4_redirects", 32'(redirectCount), 32'd0);

    // JMP while a slow read is outstanding: its word must be discarded
    $display("[TB] scenario 5: redirect over in-flight read");
    doReset();
    memLat = 3;
    for (int i = 0; i < 10 && !bus.rd_req; i++) idle(1, 1);
    checkOutput("t5_rdreq", 32'(bus.rd_req), 32'd1);
    applyStimulus(1, 1, 1, OP_JMP, 16'h0040, 12'h0, 16'h3000, 3'b000, 3'b000);
    popLog.delete();
    repeat (20) idle(1, 1);
    firstVal = (popLog.size() > 0) ? 32'(popLog[0]) : 32'hFFFF_FFFF;
    checkOutput("t5_first_pc", firstVal, 32'h3000);

    // Randomized traffic against the model
    $display("[TB] scenario 7: random traffic");
    doReset();
    spurOn = 1'b1;
    for (int seg = 0; seg < 6; seg++) begin
      memLat = $urandom_range(1, 4);
      for (int c = 0; c < 250; c++) begin
        applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
                      $urandom_range(0, 7) == 0, 4'($urandom), 16'($urandom),
                      12'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
      end
    end
    checkAll();
    spurOn = 1'b0;

    // Reset PC near the top of memory wraps through zero
    $display("[TB] scenario 6: wrap and mid-read reset");
    busHi.fetch_en = 1; busHi.instr_ready = 0;
    @(negedge clk);
    checkOutput("t6_reset_pc", 32'(busHi.pc), 32'hFFFE);
    checkOutput("t6_reset_addr", 32'(busHi.addr_out), 32'h0);
    rstHi = 1'b0;
    respNext = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      busHi.mem_rvalid = respNext;
      busHi.mem_rdata  = memData(respAddr);
      respNext = busHi.rd_req;
      respAddr = busHi.addr_out;
      if (busHi.rd_req) hiLog.push_back(busHi.addr_out);
    end
    busHi.mem_rvalid = 0;
    checkOutput("t6_reqs", 32'(hiLog.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      firstVal = (hiLog.size() > i) ? 32'(hiLog[i]) : 32'hFFFF_FFFF;
      checkOutput("t6_addr", firstVal, 32'(16'(16'hFFFE + i)));
    end
    checkOutput("t6_count", 32'(busHi.fifo_count), 32'(DEPTH));

    rstHi = 1'b1;
    @(negedge clk);
    busHi.instr_ready = 1;
    rstHi = 1'b0;
    for (int i = 0; i < 10 && !busHi.rd_req; i++) @(negedge clk);
    checkOutput("t6_inflight", 32'(busHi.rd_req), 32'd1);
    #2 rstHi = 1'b1;
    #1;
    checkOutput("t6_rst_rdreq", 32'(busHi.rd_req), 32'd0);
    checkOutput("t6_rst_addr", 32'(busHi.addr_out), 32'h0);
    checkOutput("t6_rst_pc", 32'(busHi.pc), 32'hFFFE);
    checkOutput("t6_rst_valid", 32'(busHi.instr_valid), 32'd0);
    checkOutput("t6_rst_count", 32'(busHi.fifo_count), 32'd0);
    checkOutput("t6_rst_redir", 32'(busHi.redirect_out), 32'd0);
    @(negedge clk);
    busHi.fetch_en   = 0;
    rstHi            = 1'b0;
    busHi.mem_rvalid = 1;
    busHi.mem_rdata  = 16'h1234;
    @(negedge clk);
    busHi.mem_rvalid = 0;
    @(negedge clk);
    checkOutput("t6_late_count", 32'(busHi.fifo_count), 32'd0);
    checkOutput("t6_late_valid", 32'(busHi.instr_valid), 32'd0);
    checkOutput("t6_late_rdreq", 32'(busHi.rd_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
